// File: rtl/pmem_rr_arbiter.sv
// Shares the physical-memory line port between the I-cache and D-cache.
// D wins ties, but an I request waiting behind D_BURST_MAX D grants is served next.
module pmem_rr_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int D_BURST_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int STREAK_W = $clog2(D_BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                pmemRead_q, pmemRead_d;
    logic                pmemWrite_q, pmemWrite_d;
    logic [ADDR_W-1:0]   pmemAddr_q, pmemAddr_d;
    logic [LINE_W-1:0]   pmemWdata_q, pmemWdata_d;
    logic                dReq;

    assign dReq = d_read | d_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A waiting I request takes the port once D has used up its burst allowance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dReq && i_read) begin
                    state_d = (streak_q == STREAK_MAX) ? GRANT_I : GRANT_D;
                end else if (dReq) begin
                    state_d = GRANT_D;
                end else if (i_read) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I,
            GRANT_D: begin
                if (pmem_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        streak_d    = streak_q;
        pmemRead_d  = pmemRead_q;
        pmemWrite_d = pmemWrite_q;
        pmemAddr_d  = pmemAddr_q;
        pmemWdata_d = pmemWdata_q;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_d == GRANT_I) begin
                    pmemRead_d  = 1'b1;
                    pmemWrite_d = 1'b0;
                    pmemAddr_d  = i_address;
                    streak_d    = '0;
                end else if (state_d == GRANT_D) begin
                    // A simultaneous read and write is treated as a write.
                    pmemRead_d  = ~d_write;
                    pmemWrite_d = d_write;
                    pmemAddr_d  = d_address;
                    if (d_write) begin
                        pmemWdata_d = d_wdata;
                    end
                    if (!i_read) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            GRANT_I: begin
                i_resp = pmem_resp;
                if (pmem_resp) begin
                    pmemRead_d  = 1'b0;
                    pmemWrite_d = 1'b0;
                end
            end
            GRANT_D: begin
                d_resp = pmem_resp;
                if (pmem_resp) begin
                    pmemRead_d  = 1'b0;
                    pmemWrite_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q    <= '0;
            pmemRead_q  <= 1'b0;
            pmemWrite_q <= 1'b0;
            pmemAddr_q  <= '0;
            pmemWdata_q <= '0;
        end else begin
            streak_q    <= streak_d;
            pmemRead_q  <= pmemRead_d;
            pmemWrite_q <= pmemWrite_d;
            pmemAddr_q  <= pmemAddr_d;
            pmemWdata_q <= pmemWdata_d;
        end
    end

    assign pmem_read    = pmemRead_q;
    assign pmem_write   = pmemWrite_q;
    assign pmem_address = pmemAddr_q;
    assign pmem_wdata   = pmemWdata_q;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;

    dRdWrExclusive: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: doc/pmem_rr_arbiter.md
# pmem_rr_arbiter

Registered, starvation-bounded arbiter sharing the single physical-memory line port between the I-cache (read-only) and the D-cache (read/write). D-cache requests win ties, but at most `D_BURST_MAX` consecutive D grants are issued while an I request waits. The address and write data are latched at grant, so the memory sees stable inputs for the whole transaction. Sits between the two caches and the cacheline adaptor/main memory in the CPU memory hierarchy.

## Interface
- `ADDR_W`, 32, address width.
- `LINE_W`, 256, cache-line width.
- `D_BURST_MAX`, 2, max consecutive D grants while `i_read` is pending; legal range ≥1.

Ports:
- `clk  in  1  system clock, rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `i_read  in  1  I-cache line read request, held until i_resp`
- `i_address  in  ADDR_W  I-cache line address`
- `i_rdata  out  LINE_W  read line to I-cache`
- `i_resp  out  1  I transaction complete`
- `d_read  in  1  D-cache line read request, held until d_resp`
- `d_write  in  1  D-cache line write request, held until d_resp`
- `d_address  in  ADDR_W  D-cache line address`
- `d_wdata  in  LINE_W  D-cache write line`
- `d_rdata  out  LINE_W  read line to D-cache`
- `d_resp  out  1  D transaction complete`
- `pmem_read  out  1  memory read strobe (registered)`
- `pmem_write  out  1  memory write strobe (registered)`
- `pmem_address  out  ADDR_W  latched address (registered)`
- `pmem_wdata  out  LINE_W  latched write line (registered)`
- `pmem_rdata  in  LINE_W  memory read line`
- `pmem_resp  in  1  memory transaction complete, one-cycle pulse`

## Operation
- States: `IDLE`, `GRANT_I`, `GRANT_D`, `RELEASE`.
- `IDLE` arbitration:
  - D request only (`d_read|d_write`): go to `GRANT_D`.
  - I request only: go to `GRANT_I`.
  - Both pending: go to `GRANT_D` unless `streak == D_BURST_MAX`; in that case go to `GRANT_I`.
  - Neither: stay in `IDLE`.
- On any grant edge, register `pmem_address` from the winner's address. For a D write, also register `pmem_wdata`.
- `pmem_read` is set for I grants and for D reads. `pmem_write` is set for D writes.
- `d_read & d_write` together is illegal: the write wins and a simulation assertion fires.
- `GRANT_I` / `GRANT_D`: strobes and address stay constant until `pmem_resp`.
  - `i_resp = pmem_resp & (state==GRANT_I)`; `d_resp` is the analogous term for `GRANT_D`. Both are combinational.
  - `i_rdata` and `d_rdata` pass `pmem_rdata` through unconditionally.
  - On the `pmem_resp` edge: clear strobes and go to `RELEASE`.
- `RELEASE`: one cycle so the requester can drop its request. Then go to `IDLE`. No arbitration happens in this state.
- `streak` counter, width `$clog2(D_BURST_MAX+1)`:
  - Cleared on any I grant.
  - Incremented on a D grant made while `i_read` is high, saturating at `D_BURST_MAX`.
  - Cleared on a D grant made while `i_read` is low.
- `pmem_resp` in `IDLE` or `RELEASE` is ignored: no resp output, no state change.
- Requesters deasserting before their resp is a protocol violation. The grant is held regardless.

## Timing
- Reset (`rst` low, asynchronous) sets:
  - state `IDLE`, `streak` 0;
  - `pmem_read`, `pmem_write` 0;
  - `pmem_address` 0, `pmem_wdata` 0;
  - `i_resp`, `d_resp` 0.
- Reset mid-transaction drops the strobes immediately, without waiting for a clock edge. The in-flight transaction is abandoned.
- Grant latency: a request sampled high in `IDLE` at edge N gives strobe high from edge N to edge N+1 (1 cycle).
- Completion: `pmem_resp` high in cycle M gives resp high in cycle M, strobe low after edge M, and `IDLE` after edge M+1.
- Minimum request-to-request spacing is therefore 3 cycles plus memory latency.
- Back-to-back: a request still high in `IDLE` is granted on the next edge. After `RELEASE`, an I request pending behind a D request is arbitrated normally.

## Test plan
- I-only read of `0x0000_1000`, memory answers after 4 cycles with line `0xA5…A5` → `pmem_read=1` with address `0x1000` one cycle after request; `i_resp` pulse carries the line; `d_resp` stays 0.
- D write to `0x0000_2040` with `d_wdata=0x1234…` → `pmem_write=1`, `pmem_wdata` latched; changing `d_wdata` mid-grant does not alter `pmem_wdata`; `d_resp` pulses with `pmem_resp`.
- I and D held continuously, `D_BURST_MAX=2` → grant order D, D, I, D, D, I; `streak` reads 0 after each I grant.
- Simultaneous request in the same cycle, I only pending afterwards → D served first, then I granted exactly 1 cycle after `RELEASE`.
- Stray `pmem_resp` pulse in `IDLE` and in `RELEASE` → no resp outputs, no state change.
- `rst` pulled low 2 cycles into a D read → `pmem_read` falls before the next edge; after release, an I request is granted normally with `streak` 0.
